// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback sequencer for an external combinational
// 16-bit ALU. Holds one instruction at a time, reads operands from an
// internal 8-entry register file (R0 hardwired to zero), drives the ALU for
// one cycle, captures its result and Z/N flags, then retires with a
// one-cycle DONE pulse (qualified by ERR for illegal opcodes).
module alu_issue_ctrl #(
   parameter int DW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [15:0]   INSTR,
   input  logic          LD_EN,
   input  logic [2:0]    LD_ADDR,
   input  logic [DW-1:0] LD_DATA,
   input  logic [2:0]    RD_ADDR,
   output logic [DW-1:0] RD_DATA,
   output logic          DONE,
   output logic          ERR,
   output logic [1:0]    FLAGS,
   output logic          ALU_EN,
   output logic          ALU_FLGON,
   output logic [2:0]    ALU_OP,
   output logic [DW-1:0] ALU_D1,
   output logic [DW-1:0] ALU_D2,
   input  logic [DW-1:0] ALU_RES,
   input  logic [1:0]    ALU_FLG
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_ERRS} state_t;

   state_t        r_state, w_next;
   logic [12:0]   r_instr;          // INSTR[15:3]; low bits carry no meaning
   logic [DW-1:0] r_res;
   logic [1:0]    r_flg;
   logic [DW-1:0] r_rf [1:7];       // R0 is not stored, it always reads zero
   logic          r_done, r_err, r_alu_en, r_flgon;
   logic [2:0]    r_alu_op;
   logic [DW-1:0] r_d1, r_d2;

   logic [2:0]    w_op, w_rd, w_rs1, w_rs2;
   logic          w_s, w_accept, w_illegal;
   logic          w_unused_instr;

   assign w_op      = r_instr[12:10];
   assign w_s       = r_instr[9];
   assign w_rd      = r_instr[8:6];
   assign w_rs1     = r_instr[5:3];
   assign w_rs2     = r_instr[2:0];
   assign w_illegal = (w_op > 3'd4);
   assign w_accept  = IN_VALID && (r_state == S_IDLE);
   assign w_unused_instr = ^INSTR[2:0];

   function automatic logic [DW-1:0] rf_rd(input logic [2:0] a);
      return (a == 3'd0) ? '0 : r_rf[a];
   endfunction

   assign IN_READY  = (r_state == S_IDLE);
   assign RD_DATA   = rf_rd(RD_ADDR);
   assign DONE      = r_done;
   assign ERR       = r_err;
   assign ALU_EN    = r_alu_en;
   assign ALU_FLGON = r_flgon;
   assign ALU_OP    = r_alu_op;
   assign ALU_D1    = r_d1;
   assign ALU_D2    = r_d2;

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_READ;
         S_READ: w_next = w_illegal ? S_ERRS : S_EXEC;
         S_EXEC: w_next = S_WB;
         S_WB:   w_next = S_IDLE;
         S_ERRS: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // instruction latch, operand fetch, ALU capture and registered strobes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_instr  <= '0;
         r_res    <= '0;
         r_flg    <= '0;
         r_alu_op <= '0;
         r_d1     <= '0;
         r_d2     <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_alu_en <= 1'b0;
         r_flgon  <= 1'b0;
      end else begin
         if (w_accept) r_instr <= INSTR[15:3];
         if (r_state == S_READ) begin
            r_alu_op <= w_op;
            r_d1     <= rf_rd(w_rs1);
            r_d2     <= rf_rd(w_rs2);
         end
         if (r_state == S_EXEC) begin
            r_res <= ALU_RES;
            r_flg <= ALU_FLG;
         end
         // strobes are derived from the next state so they line up with it
         r_done   <= (w_next == S_WB) || (w_next == S_ERRS);
         r_err    <= (w_next == S_ERRS);
         r_alu_en <= (w_next == S_EXEC);
         r_flgon  <= (w_next == S_EXEC) && w_s;
      end
   end

   // register file: preload any time, writeback overrides on the same entry
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 1; i < 8; i++) r_rf[i] <= '0;
      end else begin
         for (int i = 1; i < 8; i++) begin
            if (LD_EN && (LD_ADDR == 3'(i)))           r_rf[i] <= LD_DATA;
            if ((r_state == S_WB) && (w_rd == 3'(i)))  r_rf[i] <= r_res;
         end
      end
   end

   // architectural flags, only touched by a retiring S=1 instruction
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                           FLAGS <= 2'b00;
      else if ((r_state == S_WB) && w_s) FLAGS <= r_flg;
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/writeback controller that drives the 16-bit ALU's control and operand ports from the CPU side. It accepts one register-to-register instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file. It sequences the ALU enable, opcode and flag-enable, then captures the ALU result and the Z/N flags. The result is written back to the destination register and completion is signalled with a one-cycle DONE pulse.

## Interface
- DW, 16, datapath width (operands, result, register file entries)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  instruction valid
- IN_READY  out  1  controller can accept an instruction; high only in IDLE
- INSTR  in  16  [15:13] OP, [12] S (set flags), [11:9] RD, [8:6] RS1, [5:3] RS2, [2:0] ignored
- LD_EN  in  1  register preload strobe
- LD_ADDR  in  3  preload address
- LD_DATA  in  DW  preload data
- RD_ADDR  in  3  debug read address
- RD_DATA  out  DW  debug read data, combinational; R0 always reads 0
- DONE  out  1  one-cycle pulse at writeback or error retire
- ERR  out  1  qualifies DONE: illegal opcode, no state changed
- FLAGS  out  2  architectural flags, [1]=Z, [0]=N
- ALU_EN  out  1  ALU enable
- ALU_FLGON  out  1  ALU flag enable
- ALU_OP  out  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 not(D1)
- ALU_D1, ALU_D2  out  DW  ALU operands
- ALU_RES  in  DW  ALU result, ALUREG, combinational from ALU inputs
- ALU_FLG  in  2  ALU flags, [1]=zero, [0]=negative

## Operation
- States: IDLE, READ, EXEC, WB, ERRS. Reset enters IDLE.
- IDLE: IN_READY=1. On IN_VALID&IN_READY, latch INSTR and go to READ.
- READ: register ALU_OP<=OP, ALU_D1<=R[RS1], ALU_D2<=R[RS2].
  - OP in 101..111 goes to ERRS.
  - Otherwise goes to EXEC.
- EXEC: ALU_EN=1, ALU_FLGON=S. At the cycle end, capture ALU_RES and ALU_FLG into internal holding registers, then go to WB.
- WB: R[RD]<=captured result (ignored when RD=0). FLAGS<=captured flags only when S=1. DONE=1, then go to IDLE.
- ERRS: DONE=1, ERR=1. No register or FLAGS write. Then go to IDLE.
- Register file: 8 entries. R0 is hardwired to 0 and writes to it are discarded.
- Preload: LD_EN writes R[LD_ADDR]<=LD_DATA in any state.
  - If LD_EN targets the same register as a WB write in the same cycle, the WB write wins.
  - A preload in the same cycle as READ is not visible to that READ; READ sees the old value.
- Arithmetic: 16-bit modulo, no carry out. The controller passes values through unmodified. Z and N come only from the ALU.
- ALU_EN=0 and ALU_FLGON=0 in every state except EXEC.

## Timing
- Reset values:
  - State IDLE; IN_READY=1.
  - DONE=0, ERR=0, FLAGS=00.
  - ALU_EN=0, ALU_FLGON=0, ALU_OP=000, ALU_D1=0, ALU_D2=0.
  - All registers 0.
- Latency: handshake in cycle 0, READ in cycle 1, EXEC in cycle 2, DONE high in cycle 3. The RF write and FLAGS become visible from cycle 4.
- Throughput: one instruction per 4 cycles. IN_READY is low in cycles 1-3 and high again in cycle 4.
- Illegal-op latency: handshake in cycle 0, READ in cycle 1, DONE+ERR in cycle 2, IN_READY high in cycle 3.
- IN_VALID held high while IN_READY=0 is ignored. INSTR is sampled only on the handshake cycle, so later changes to INSTR have no effect.
- Read-after-write: an instruction accepted in cycle 4 reads the RD value written in cycle 3.
- DONE and ERR are registered outputs, each high for exactly one cycle.
- RST asserted mid-instruction:
  - The controller returns to IDLE immediately and the in-flight instruction is dropped.
  - No DONE is issued; the register file and FLAGS are cleared.

## Test plan
- Preload R1=10, R2=5; issue ADD R3,R1,R2 with S=0 -> DONE in cycle 3, RD_DATA(R3)=15, FLAGS stays 00, ALU_FLGON=0 throughout.
- Preload R1=0xCCCC, R2=0xAAAA; issue AND R4, then OR R5, then NOT R6,R2 -> R4=0x8888, R5=0xEEEE, R6=0x5555.
- Preload R1=5, R2=10; issue SUB R3,R1,R2 with S=1 -> R3=0xFFFB, FLAGS=01. Then SUB R3,R7,R7 (R7=7) with S=1 -> R3=0, FLAGS=10. Then SUB with S=0 -> FLAGS stays 10.
- Back-to-back: hold IN_VALID high with ADD R1,R1,R1 (R1=1) for 3 instructions -> handshakes 4 cycles apart, R1 ends at 8, each read sees the prior write.
- Issue OP=110 -> DONE=1, ERR=1 in cycle 2. Also issue a write to RD=0 -> R0 still reads 0. In both cases the register file and FLAGS are unchanged.
- Collision and reset:
  - LD_EN to R3 with value 0x1234 in the same cycle as WB to R3 with result 15 -> R3=15.
  - Assert RST during EXEC -> no DONE, all outputs at reset values, IN_READY=1 after release.
